// File: rtl/ppi_portc_hs.sv
// ppi_portc_hs: clocked PPI port C block with BSR, mode-0 nibble direction
// and mode-1 strobed input for port A (nSTB=PC4, IBF=PC5, INTR=PC3) backed
// by a small input FIFO with overrun detection.
// Optional build macro PPI_OVERRUN_INTR_EN: overrun also raises INTR
// (gated by INTE) until the status register is read.
module ppi_portc_hs #(
   parameter int DW         = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic          nCs,
   input  logic          nRd,
   input  logic          nWr,
   input  logic [1:0]    A,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic          dout_en,
   input  logic [DW-1:0] pa_in,
   input  logic [7:0]    pc_in,
   output logic [7:0]    pc_out,
   output logic [7:0]    pc_oe
);

   localparam int PW = $clog2(FIFO_DEPTH);

   logic [7:0]    ctrl;
   logic [7:0]    pcLatch;
   logic          inte;
   logic          overrun;
   logic [DW-1:0] fifoMem [FIFO_DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic [3:0]    fifoCount;
   logic          wrPrev;
   logic          rdPrev;
   logic          nstbMeta;
   logic          nstbSync;
   logic          nstbPrev;

   logic          wrActive;
   logic          rdActive;
   logic          wrStart;
   logic          rdStart;
   logic          ctrlWrite;
   logic          bsrWrite;
   logic          pcWrite;
   logic          statusRead;
   logic          mode1;
   logic          fifoEmpty;
   logic          fifoFull;
   logic          ibf;
   logic          intr;
   logic          stbFall;
   logic          pushReq;
   logic          pushOk;
   logic          popReq;
   logic          overrunSet;
   logic          bsrIgnored;
   logic [7:0]    pcOe;
   logic [7:0]    pcDrive;
   logic [7:0]    headExt;
   logic [7:0]    paExt;
   logic [7:0]    readData;

   assign wrActive   = !nCs && !nWr;
   assign rdActive   = !nCs && !nRd;
   assign wrStart    = wrActive && !wrPrev;
   assign rdStart    = rdActive && !rdPrev;
   assign ctrlWrite  = wrStart && (A == 2'b11) && din[7];
   assign bsrWrite   = wrStart && (A == 2'b11) && !din[7];
   assign pcWrite    = wrStart && (A == 2'b10);
   assign statusRead = rdStart && (A == 2'b01);

   assign mode1      = (ctrl[6:5] != 2'b00);
   assign fifoEmpty  = (fifoCount == 4'd0);
   assign fifoFull   = (fifoCount == 4'(FIFO_DEPTH));
   assign ibf        = !fifoEmpty;

   assign stbFall    = nstbPrev && !nstbSync;
   assign pushReq    = stbFall && mode1;
   assign popReq     = rdStart && (A == 2'b00) && mode1 && !fifoEmpty;
   assign pushOk     = pushReq && (!fifoFull || popReq);
   assign overrunSet = pushReq && fifoFull && !popReq;

   // In mode 1 the handshake pins PC3 and PC5 are owned by the FIFO logic.
   assign bsrIgnored = mode1 && ((din[3:1] == 3'd3) || (din[3:1] == 3'd5));

`ifdef PPI_OVERRUN_INTR_EN
   assign intr = inte && ((ibf && nstbSync) || overrun);
`else
   assign intr = inte && ibf && nstbSync;
`endif

   // Port C direction: nibble-wise in mode 0, fixed handshake pins in mode 1.
   always_comb begin
      pcOe = '0;
      if (mode1) begin
         pcOe = {{2{~ctrl[3]}}, 1'b1, 1'b0, 1'b1, {3{~ctrl[0]}}};
      end else begin
         pcOe = {{4{~ctrl[3]}}, {4{~ctrl[0]}}};
      end
   end

   // Pin values: latch bits, with IBF/INTR substituted in mode 1, masked by direction.
   always_comb begin
      pcDrive = pcLatch;
      if (mode1) begin
         pcDrive[5] = ibf;
         pcDrive[3] = intr;
      end
   end

   assign pc_oe  = pcOe;
   assign pc_out = pcDrive & pcOe;

   // Bus read mux, zero-extending port A data narrower than the bus.
   always_comb begin
      headExt = '0;
      paExt   = '0;
      headExt[DW-1:0] = fifoMem[rdPtr];
      paExt[DW-1:0]   = pa_in;
      readData = '0;
      case (A)
         2'b00: begin
            if (mode1) begin
               readData = fifoEmpty ? 8'h00 : headExt;
            end else begin
               readData = paExt;
            end
         end
         2'b01: readData = {overrun, 3'b000, fifoCount};
         2'b10: begin
            readData = (pcLatch & pcOe) | (pc_in & ~pcOe);
            if (mode1) begin
               readData[4] = inte;
            end
         end
         default: readData = ctrl;
      endcase
   end

   // Two-flop synchronizer for nSTB plus one delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (Reset) begin
         nstbMeta <= 1'b1;
         nstbSync <= 1'b1;
         nstbPrev <= 1'b1;
      end else begin
         nstbMeta <= pc_in[4];
         nstbSync <= nstbMeta;
         nstbPrev <= nstbSync;
      end
   end

   // FIFO storage; pointers and count decide which entries are valid.
   always_ff @(posedge clk) begin
      if (!Reset && pushOk && !ctrlWrite) begin
         fifoMem[wrPtr] <= pa_in;
      end
   end

   // Bus cycle tracking, register file, FIFO pointers and status flags.
   always_ff @(posedge clk) begin
      if (Reset) begin
         ctrl      <= 8'h9B;
         pcLatch   <= '0;
         inte      <= 1'b0;
         overrun   <= 1'b0;
         rdPtr     <= '0;
         wrPtr     <= '0;
         fifoCount <= '0;
         wrPrev    <= 1'b0;
         rdPrev    <= 1'b0;
         dout      <= '0;
         dout_en   <= 1'b0;
      end else begin
         wrPrev  <= wrActive;
         rdPrev  <= rdActive;
         dout_en <= rdActive;
         if (rdStart) begin
            dout <= readData;
         end
         if (ctrlWrite) begin
            ctrl      <= din;
            pcLatch   <= '0;
            inte      <= 1'b0;
            overrun   <= 1'b0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            fifoCount <= '0;
         end else begin
            if (bsrWrite) begin
               if (mode1 && (din[3:1] == 3'd4)) begin
                  inte <= din[0];
               end else if (!bsrIgnored) begin
                  pcLatch[din[3:1]] <= din[0];
               end
            end
            if (pcWrite) begin
               pcLatch <= din;
            end
            if (pushOk) begin
               wrPtr <= wrPtr + 1'b1;
            end
            if (popReq) begin
               rdPtr <= rdPtr + 1'b1;
            end
            if (pushOk && !popReq) begin
               fifoCount <= fifoCount + 4'd1;
            end else if (popReq && !pushOk) begin
               fifoCount <= fifoCount - 4'd1;
            end
            if (overrunSet) begin
               overrun <= 1'b1;
            end else if (statusRead) begin
               overrun <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ppi_portc_hs.sv
// tb_ppi_portc_hs: scoreboard bench for ppi_portc_hs (DW=8, FIFO_DEPTH=4).
// Port A data is queued as strobes are driven and compared as it is read back.
module tb_ppi_portc_hs;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk;
   logic          Reset;
   logic          nCs;
   logic          nRd;
   logic          nWr;
   logic [1:0]    A;
   logic [7:0]    din;
   logic [7:0]    dout;
   logic          dout_en;
   logic [DW-1:0] pa_in;
   logic [7:0]    pc_in;
   logic [7:0]    pc_out;
   logic [7:0]    pc_oe;

   int            passCount = 0;
   int            checkCount = 0;
   logic [7:0]    expQ[$];
   logic          modelOverrun = 1'b0;

   ppi_portc_hs #(.DW(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .Reset(Reset), .nCs(nCs), .nRd(nRd), .nWr(nWr), .A(A),
      .din(din), .dout(dout), .dout_en(dout_en), .pa_in(pa_in),
      .pc_in(pc_in), .pc_out(pc_out), .pc_oe(pc_oe)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyWrite(input logic [1:0] addr, input logic [7:0] data);
      @(posedge clk); #1;
      nCs = 1'b0; nWr = 1'b0; A = addr; din = data;
      @(posedge clk); #1;
      nCs = 1'b1; nWr = 1'b1;
   endtask

   task automatic applyRead(input logic [1:0] addr, output logic [7:0] data);
      @(posedge clk); #1;
      nCs = 1'b0; nRd = 1'b0; A = addr;
      @(posedge clk); #1;
      nCs = 1'b1; nRd = 1'b1;
      data = dout;
   endtask

   // One strobe: nSTB low 4 cycles then high 3 cycles; model the FIFO push
   task automatic applyStrobe(input logic [7:0] value);
      @(posedge clk); #1;
      pa_in = value;
      pc_in[4] = 1'b0;
      if (expQ.size() < DEPTH) expQ.push_back(value);
      else modelOverrun = 1'b1;
      repeat (4) @(posedge clk);
      #1 pc_in[4] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] modelStatus();
      return {modelOverrun, 3'b000, 4'(expQ.size())};
   endfunction

   task automatic test_reset();
      logic [7:0] rd;
      @(posedge clk); #1;
      Reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 Reset = 1'b0;
      expQ.delete();
      modelOverrun = 1'b0;
      checkCount++; if (pc_oe !== 8'h00) $display("[TB] FAIL reset_pc_oe: got %h expected %h", pc_oe, 8'h00); else passCount++;
      checkCount++; if (pc_out !== 8'h00) $display("[TB] FAIL reset_pc_out: got %h expected %h", pc_out, 8'h00); else passCount++;
      checkCount++; if (dout_en !== 1'b0) $display("[TB] FAIL reset_dout_en: got %b expected %b", dout_en, 1'b0); else passCount++;
      checkCount++; if (dout !== 8'h00) $display("[TB] FAIL reset_dout: got %h expected %h", dout, 8'h00); else passCount++;
      @(posedge clk); #1;
      nCs = 1'b0; nRd = 1'b0; A = 2'b11;
      @(posedge clk); #1;
      checkCount++; if (dout_en !== 1'b1) $display("[TB] FAIL read_dout_en: got %b expected %b", dout_en, 1'b1); else passCount++;
      checkCount++; if (dout !== 8'h9B) $display("[TB] FAIL reset_ctrl: got %h expected %h", dout, 8'h9B); else passCount++;
      nCs = 1'b1; nRd = 1'b1;
      applyRead(2'b01, rd);
      checkCount++; if (rd !== modelStatus()) $display("[TB] FAIL reset_status: got %h expected %h", rd, modelStatus()); else passCount++;
   endtask

   task automatic test_bsr_mode0();
      logic [7:0] rd;
      applyWrite(2'b11, 8'h80);
      applyWrite(2'b11, 8'h0B);
      checkCount++; if (pc_oe !== 8'hFF) $display("[TB] FAIL m0_pc_oe: got %h expected %h", pc_oe, 8'hFF); else passCount++;
      checkCount++; if (pc_out !== 8'h20) $display("[TB] FAIL bsr_set5: got %h expected %h", pc_out, 8'h20); else passCount++;
      applyRead(2'b10, rd);
      checkCount++; if (rd !== 8'h20) $display("[TB] FAIL m0_portc_read: got %h expected %h", rd, 8'h20); else passCount++;
      applyWrite(2'b11, 8'h0A);
      checkCount++; if (pc_out !== 8'h00) $display("[TB] FAIL bsr_clr5: got %h expected %h", pc_out, 8'h00); else passCount++;
      // Upper nibble input: only low latch bits reach the pins
      applyWrite(2'b11, 8'h88);
      applyWrite(2'b10, 8'hA5);
      checkCount++; if (pc_oe !== 8'h0F) $display("[TB] FAIL m0_upper_in_oe: got %h expected %h", pc_oe, 8'h0F); else passCount++;
      checkCount++; if (pc_out !== 8'h05) $display("[TB] FAIL m0_upper_in_out: got %h expected %h", pc_out, 8'h05); else passCount++;
      pa_in = 8'h3C;
      applyRead(2'b00, rd);
      checkCount++; if (rd !== 8'h3C) $display("[TB] FAIL m0_porta_read: got %h expected %h", rd, 8'h3C); else passCount++;
   endtask

   task automatic test_mode1_single();
      logic [7:0] rd;
      logic       seen;
      applyWrite(2'b11, 8'hB9);
      applyWrite(2'b11, 8'h09);
      expQ.delete();
      modelOverrun = 1'b0;
      checkCount++; if (pc_oe !== 8'h28) $display("[TB] FAIL m1_pc_oe: got %h expected %h", pc_oe, 8'h28); else passCount++;
      applyRead(2'b10, rd);
      checkCount++; if (rd !== 8'h10) $display("[TB] FAIL m1_inte_read: got %h expected %h", rd, 8'h10); else passCount++;
      @(posedge clk); #1;
      pa_in = 8'h5A;
      pc_in[4] = 1'b0;
      expQ.push_back(8'h5A);
      seen = 1'b0;
      for (int i = 0; i < 3 && !seen; i++) begin
         @(posedge clk); #1;
         if (pc_out[5] === 1'b1) seen = 1'b1;
      end
      checkCount++; if (seen !== 1'b1) $display("[TB] FAIL ibf_within_3: got %b expected %b", seen, 1'b1); else passCount++;
      checkCount++; if (pc_out[3] !== 1'b0) $display("[TB] FAIL intr_while_stb_low: got %b expected %b", pc_out[3], 1'b0); else passCount++;
      repeat (2) @(posedge clk);
      #1 pc_in[4] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkCount++; if (pc_out !== 8'h28) $display("[TB] FAIL ibf_intr_high: got %h expected %h", pc_out, 8'h28); else passCount++;
      applyRead(2'b00, rd);
      checkCount++; if (rd !== expQ[0]) $display("[TB] FAIL m1_single_data: got %h expected %h", rd, expQ[0]); else passCount++;
      void'(expQ.pop_front());
      checkCount++; if (pc_out !== 8'h00) $display("[TB] FAIL ibf_intr_clear: got %h expected %h", pc_out, 8'h00); else passCount++;
   endtask

   task automatic test_overrun();
      logic [7:0] rd;
      logic [7:0] exp;
      applyWrite(2'b11, 8'hB9);
      expQ.delete();
      modelOverrun = 1'b0;
      for (int i = 1; i <= 5; i++) applyStrobe(8'(i));
      exp = modelStatus();
      applyRead(2'b01, rd);
      modelOverrun = 1'b0;
      checkCount++; if (rd !== exp) $display("[TB] FAIL overrun_status: got %h expected %h", rd, exp); else passCount++;
      for (int i = 0; i < 5; i++) begin
         exp = (expQ.size() != 0) ? expQ.pop_front() : 8'h00;
         applyRead(2'b00, rd);
         checkCount++; if (rd !== exp) $display("[TB] FAIL overrun_drain%0d: got %h expected %h", i, rd, exp); else passCount++;
      end
      applyRead(2'b01, rd);
      checkCount++; if (rd !== modelStatus()) $display("[TB] FAIL overrun_status_after: got %h expected %h", rd, modelStatus()); else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd;
      logic [7:0] exp;
      applyWrite(2'b11, 8'hB9);
      expQ.delete();
      modelOverrun = 1'b0;
      for (int i = 0; i < DEPTH; i++) applyStrobe(8'h11 + 8'(i));
      // Time the port A read so its rd_start meets the push edge
      @(posedge clk); #1;
      pa_in = 8'h15;
      pc_in[4] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      nCs = 1'b0; nRd = 1'b0; A = 2'b00;
      @(posedge clk); #1;
      nCs = 1'b1; nRd = 1'b1;
      exp = expQ.pop_front();
      expQ.push_back(8'h15);
      checkCount++; if (dout !== exp) $display("[TB] FAIL full_push_pop_data: got %h expected %h", dout, exp); else passCount++;
      repeat (2) @(posedge clk);
      #1 pc_in[4] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      applyRead(2'b01, rd);
      checkCount++; if (rd !== modelStatus()) $display("[TB] FAIL full_push_pop_status: got %h expected %h", rd, modelStatus()); else passCount++;
      while (expQ.size() != 0) begin
         exp = expQ.pop_front();
         applyRead(2'b00, rd);
         checkCount++; if (rd !== exp) $display("[TB] FAIL wrap_drain: got %h expected %h", rd, exp); else passCount++;
      end
   endtask

   task automatic test_reset_midstream();
      logic [7:0] rd;
      applyWrite(2'b11, 8'hB9);
      applyWrite(2'b11, 8'h09);
      expQ.delete();
      modelOverrun = 1'b0;
      applyStrobe(8'h21);
      applyStrobe(8'h22);
      checkCount++; if (pc_out[5] !== 1'b1) $display("[TB] FAIL pre_reset_ibf: got %b expected %b", pc_out[5], 1'b1); else passCount++;
      @(posedge clk); #1;
      pa_in = 8'h23;
      pc_in[4] = 1'b0;
      @(posedge clk); #1;
      Reset = 1'b1;
      nCs = 1'b0; nWr = 1'b0; A = 2'b10; din = 8'hFF;
      @(posedge clk); #1;
      Reset = 1'b0;
      nCs = 1'b1; nWr = 1'b1;
      expQ.delete();
      modelOverrun = 1'b0;
      checkCount++; if (pc_oe !== 8'h00) $display("[TB] FAIL midreset_pc_oe: got %h expected %h", pc_oe, 8'h00); else passCount++;
      checkCount++; if (pc_out !== 8'h00) $display("[TB] FAIL midreset_pc_out: got %h expected %h", pc_out, 8'h00); else passCount++;
      checkCount++; if (dout_en !== 1'b0) $display("[TB] FAIL midreset_dout_en: got %b expected %b", dout_en, 1'b0); else passCount++;
      pc_in[4] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      applyRead(2'b01, rd);
      checkCount++; if (rd !== modelStatus()) $display("[TB] FAIL midreset_status: got %h expected %h", rd, modelStatus()); else passCount++;
      applyRead(2'b11, rd);
      checkCount++; if (rd !== 8'h9B) $display("[TB] FAIL midreset_ctrl: got %h expected %h", rd, 8'h9B); else passCount++;
   endtask

   task automatic test_overrun_intr();
      logic [7:0] rd;
      logic [7:0] exp;
      logic       expIntr;
`ifdef PPI_OVERRUN_INTR_EN
      expIntr = 1'b1;
`else
      expIntr = 1'b0;
`endif
      applyWrite(2'b11, 8'hB9);
      applyWrite(2'b11, 8'h09);
      expQ.delete();
      modelOverrun = 1'b0;
      for (int i = 0; i < 5; i++) applyStrobe(8'h40 + 8'(i));
      while (expQ.size() != 0) begin
         exp = expQ.pop_front();
         applyRead(2'b00, rd);
         checkCount++; if (rd !== exp) $display("[TB] FAIL ovr_intr_drain: got %h expected %h", rd, exp); else passCount++;
      end
      checkCount++; if (pc_out[3] !== expIntr) $display("[TB] FAIL ovr_intr_level: got %b expected %b", pc_out[3], expIntr); else passCount++;
      exp = modelStatus();
      applyRead(2'b01, rd);
      modelOverrun = 1'b0;
      checkCount++; if (rd !== exp) $display("[TB] FAIL ovr_intr_status: got %h expected %h", rd, exp); else passCount++;
      checkCount++; if (pc_out[3] !== 1'b0) $display("[TB] FAIL ovr_intr_cleared: got %b expected %b", pc_out[3], 1'b0); else passCount++;
   endtask

   // Scenario sequence
   initial begin
      Reset = 1'b0;
      nCs = 1'b1; nRd = 1'b1; nWr = 1'b1;
      A = 2'b00; din = 8'h00;
      pa_in = '0;
      pc_in = 8'h10;
      test_reset();
      test_bsr_mode0();
      test_mode1_single();
      test_overrun();
      test_back_to_back();
      test_reset_midstream();
      test_overrun_intr();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
